// File: rtl/program_loader.sv
// program_loader
//   Boot-time loader that sits in front of the fetch/decode/execute pipeline.
//   After a start pulse it reads a 4-byte big-endian word count N from the
//   UART RX stream, then assembles N big-endian 32-bit words and writes them
//   to instruction memory starting at word address 0. It reports a running
//   checksum (sum mod 2^32) and raises done when the load completes. It raises
//   err on an oversize header or when the byte stream goes idle for too long.
//
// Ports
//   clk, rst      system clock; synchronous active-high reset
//   start         one-cycle pulse that begins a load (ignored while busy)
//   rx_data       received UART byte
//   rx_valid      one-cycle strobe qualifying rx_data
//   imem_addr     instruction memory word address (holds when imem_we=0)
//   imem_din      instruction word to write (holds when imem_we=0)
//   imem_we       one-cycle write enable
//   busy          high while reading the header or data
//   done          load finished; held until rst or the next start
//   err           load aborted; held until rst or the next start
//   words_loaded  number of words written in the current load
//   checksum      sum mod 2^32 of the words written in the current load
module program_loader #(
  parameter int ADDR_W      = 14,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_din,
  output logic              imem_we,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_loaded,
  output logic [31:0]       checksum
);

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_DATA, S_DONE, S_ERR} state_t;

  localparam int              TW       = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [TW-1:0]   TMO_ONE  = TW'(1);
  localparam logic [32:0]     CAP      = 33'(1) << ADDR_W;
  localparam logic [ADDR_W:0] WL_ONE   = (ADDR_W+1)'(1);

  state_t            state;
  logic [1:0]        byte_cnt;
  logic [23:0]       shreg;    // first three bytes of the word in progress
  logic [ADDR_W:0]   len_q;    // validated word count, always <= 2**ADDR_W
  logic [TW-1:0]     tmo_cnt;

  // The current byte completes the word combinationally, so the write can
  // be registered on the same edge that samples the 4th byte.
  logic [31:0] word_w;
  logic        byte_last;
  assign word_w    = {shreg, rx_data};
  assign byte_last = (byte_cnt == 2'd3);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      byte_cnt     <= '0;
      shreg        <= '0;
      len_q        <= '0;
      tmo_cnt      <= '0;
      imem_addr    <= '0;
      imem_din     <= '0;
      imem_we      <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      words_loaded <= '0;
      checksum     <= '0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state        <= S_HDR;
            busy         <= 1'b1;
            done         <= 1'b0;
            err          <= 1'b0;
            words_loaded <= '0;
            checksum     <= '0;
            byte_cnt     <= '0;
            tmo_cnt      <= '0;
          end
        end
        S_HDR, S_DATA: begin
          // words_loaded has already absorbed the final write here, so this
          // fires in the write cycle and done appears one cycle later.
          if (state == S_DATA && words_loaded == len_q) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (rx_valid) begin
            // A byte always beats a coincident timeout expiry.
            tmo_cnt  <= '0;
            byte_cnt <= byte_cnt + 2'd1;
            shreg    <= word_w[23:0];
            if (byte_last) begin
              if (state == S_HDR) begin
                if (word_w == 32'd0) begin
                  state <= S_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                end else if ({1'b0, word_w} > CAP) begin
                  state <= S_ERR;
                  busy  <= 1'b0;
                  err   <= 1'b1;
                end else begin
                  len_q <= word_w[ADDR_W:0];
                  state <= S_DATA;
                end
              end else begin
                imem_we      <= 1'b1;
                imem_din     <= word_w;
                imem_addr    <= words_loaded[ADDR_W-1:0];
                words_loaded <= words_loaded + WL_ONE;
                checksum     <= checksum + word_w;
              end
            end
          end else if (tmo_cnt == TMO_LAST) begin
            // Any partial word is simply dropped.
            state <= S_ERR;
            busy  <= 1'b0;
            err   <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_ONE;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Boot-time loader that sits upstream of the fetch/decode/execute pipeline.
- While the core is in LOAD mode, after the 0xAA handshake byte has been sent, it consumes the UART RX byte stream and assembles big-endian 32-bit words. It writes those words sequentially into instruction memory from word address 0.
- On completion it raises done; top-level control uses done to switch mode to EXEC and release PC from 0.
- It also reports a running 32-bit word checksum so the host can verify the upload.

Parameters:
- ADDR_W, 14, instruction memory word-address width; capacity is 2**ADDR_W words.
- TIMEOUT_CYC, 1000000, maximum idle clk cycles allowed between bytes while a load is in progress.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse to begin a load (mode==LOAD and 0xAA sent).
- rx_data  in  8  received UART byte.
- rx_valid  in  1  one-cycle strobe; rx_data is valid this cycle.
- imem_addr  out  ADDR_W  instruction memory word address.
- imem_din  out  32  instruction word to write.
- imem_we  out  1  one-cycle write enable.
- busy  out  1  high in HDR or DATA state.
- done  out  1  high in DONE state; held until rst or a new start.
- err  out  1  high in ERR state; held until rst or a new start.
- words_loaded  out  ADDR_W+1  count of words written in the current load.
- checksum  out  32  sum mod 2^32 of all words written in the current load.

Behaviour:
- States: IDLE, HDR, DATA, DONE, ERR.
- Reset:
  - State returns to IDLE.
  - All outputs go to 0: imem_addr, imem_din, imem_we, busy, done, err, words_loaded, checksum.
  - Internal byte counter, length register and timeout counter are cleared.
  - Reset mid-load abandons the load; no further imem_we is issued.
- start handling:
  - In IDLE, DONE or ERR: go to HDR next cycle; clear words_loaded, checksum, byte counter and timeout counter; drop done and err.
  - In HDR or DATA: start is ignored.
- rx_valid in IDLE, DONE or ERR: ignored.
- HDR: 4 bytes, MSB first, form word count N (32-bit).
  - After the 4th byte: N==0 → DONE next cycle, no write.
  - N > 2**ADDR_W → ERR.
  - Otherwise → DATA.
- DATA: every 4 bytes, MSB first, form one word. In the cycle after the 4th byte's rx_valid:
  - imem_we=1 for exactly one cycle.
  - imem_din = assembled word.
  - imem_addr = words_loaded[ADDR_W-1:0] (the pre-increment value).
  - Same edge: words_loaded += 1; checksum += word, wrapping mod 2^32.
- Leaving DATA: when words_loaded reaches N, go to DONE in the cycle after the last write. done rises the cycle after the final imem_we pulse.
- imem_addr and imem_din hold their last values when imem_we=0.
- Byte timing:
  - Back-to-back rx_valid on consecutive cycles must be accepted with no byte lost.
  - Latency from 4th-byte strobe to imem_we is 1 cycle; throughput is 1 word per 4 byte strobes.
- Timeout:
  - In HDR/DATA the timeout counter increments each cycle without rx_valid and resets to 0 on rx_valid.
  - Reaching TIMEOUT_CYC → ERR. A partial word is discarded with no write.
- Simultaneous rx_valid and timeout expiry in the same cycle: rx_valid wins; the byte is accepted and the counter is cleared.
- Boundary N == 2**ADDR_W: accepted. The last write goes to address 2**ADDR_W-1 and words_loaded ends at 2**ADDR_W (hence ADDR_W+1 bits).
- busy = (state==HDR || state==DATA).

Test Plan:
- rst, start, bytes 00 00 00 02 | 12 34 56 78 | DE AD BE EF → two imem_we pulses: addr 0 / 0x12345678, then addr 1 / 0xDEADBEEF. words_loaded=2, checksum=0xF0E21567; done rises the cycle after the 2nd write.
- start, header 00 00 00 00 → no imem_we; done=1 one cycle after the 4th byte; words_loaded=0.
- ADDR_W=4, header 00 00 00 11 (17) → err=1, no writes, later bytes ignored. A new start clears err and a 1-word load succeeds.
- TIMEOUT_CYC=16, header N=1, then bytes AA BB followed by silence → err asserts 16 cycles after byte BB; no imem_we.
- 12 bytes (N=2 load) on consecutive cycles, with start pulsed during DATA and rst asserted one cycle after the first write → start ignored; after rst all outputs 0, state IDLE, no second write.
- Checksum wrap: N=2, words FFFFFFFF and 00000002 → checksum=0x00000001.
